// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_gen_pkg
// Purpose  : Shared definitions for the pulse burst generator: FSM state
//            encoding, default widths and the max1() phase-length helper.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_gen_pkg;

  // Default widths for the burst counter and phase timer.
  localparam int C_CNT_W = 32;
  localparam int C_PH_W  = 16;

  // Burst FSM state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A phase length of zero is treated as one clock so every pulse has a
  // visible high and low phase. Works on a 32-bit container; callers
  // narrow the result back to their own width (phase widths up to 32 bits).
  function automatic logic [31:0] max1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_burst_gen_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Purpose  : Down-counter timing the high and low phases of each pulse.
//            A load captures i_value; the counter then decrements once per
//            clock and o_expire flags the last cycle of the loaded count.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset, clears the count
//            i_load    - load i_value on this edge (wins over decrement)
//            i_value   - phase length in clocks (expected >= 1)
//            o_expire  - high during the final cycle of the loaded phase
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int PH_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [PH_W-1:0] i_value,
  output logic            o_expire
);

  logic [PH_W-1:0] r_count;

  // The loaded value is the number of cycles remaining including the
  // current one, so the last cycle of the phase is the one showing 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - PH_W'(1);
    end
  end

  assign o_expire = (r_count == PH_W'(1));

endmodule
`default_nettype wire

// File: rtl/pulse_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_gen
// Purpose  : Programmable pulse-train transmitter. On an accepted start it
//            emits burst_len pulses, each max(high_cycles,1) clocks high and
//            max(low_cycles,1) clocks low, on a registered output, and
//            reports busy / done / running sent-pulse count.
// Options  : PULSE_GEN_ABORT_EN - adds the abort input; abort in HIGH or LOW
//            ends the burst on the next edge with a done strobe.
// Ports    : CLOCK_50    - system clock, rising edge
//            RESET       - synchronous active-high reset
//            start       - start request, sampled only in IDLE
//            burst_len   - pulses per burst, latched at start (0 = ignored)
//            high_cycles - high phase length, latched at start (0 -> 1)
//            low_cycles  - low phase length, latched at start (0 -> 1)
//            abort       - burst abort (PULSE_GEN_ABORT_EN only)
//            pulse_out   - registered pulse train
//            busy        - high for every HIGH/LOW cycle of the burst
//            done        - one-cycle strobe after the last LOW cycle
//            sent_count  - pulses completed in the current or last burst
// Revision : 1.0 - initial release
// ============================================================================
module pulse_burst_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = C_CNT_W,
  parameter int PH_W  = C_PH_W     // must not exceed 32 (max1 container)
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [PH_W-1:0]  high_cycles,
  input  logic [PH_W-1:0]  low_cycles,
`ifdef PULSE_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_len;      // latched burst length
  logic [PH_W-1:0]  r_high;     // latched, already forced to >= 1
  logic [PH_W-1:0]  r_low;      // latched, already forced to >= 1
  logic [CNT_W-1:0] r_sent;
  logic             r_pulse;

  // --------------------------------------------------------------------------
  // Combinational controls
  // --------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic             w_accept;   // start taken this cycle: latch parameters
  logic             w_inc;      // a high phase completed this cycle
  logic             w_load;
  logic [PH_W-1:0]  w_load_val;
  logic             w_expire;
  logic             w_abort;
  logic [PH_W-1:0]  w_h_in;
  logic [PH_W-1:0]  w_l_in;

  assign w_h_in = PH_W'(max1(32'(high_cycles)));
  assign w_l_in = PH_W'(max1(32'(low_cycles)));

`ifdef PULSE_GEN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Phase timer
  // --------------------------------------------------------------------------
  phase_timer #(
    .PH_W (PH_W)
  ) u_phase_timer (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_inc       = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;

    case (r_state)
      IDLE: begin
        // A zero-length request is dropped without a done strobe.
        if (start && (burst_len != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = HIGH;
          w_load      = 1'b1;
          w_load_val  = w_h_in;
        end
      end

      HIGH: begin
        // Abort takes priority over phase completion, so a high phase
        // cut short in its final cycle is not counted.
        if (w_abort) begin
          w_state_nxt = DONE;
        end else if (w_expire) begin
          w_state_nxt = LOW;
          w_inc       = 1'b1;
          w_load      = 1'b1;
          w_load_val  = r_low;
        end
      end

      LOW: begin
        if (w_abort) begin
          w_state_nxt = DONE;
        end else if (w_expire) begin
          // r_sent already includes the pulse whose low phase ends now.
          if (r_sent == r_len) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = HIGH;
            w_load      = 1'b1;
            w_load_val  = r_high;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state <= IDLE;
      r_pulse <= 1'b0;
      r_len   <= '0;
      r_high  <= '0;
      r_low   <= '0;
      r_sent  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Registering the decoded next state keeps pulse_out glitch-free and
      // aligned with the state it describes.
      r_pulse <= (w_state_nxt == HIGH);

      if (w_accept) begin
        r_len  <= burst_len;
        r_high <= w_h_in;
        r_low  <= w_l_in;
        r_sent <= '0;
      end else if (w_inc) begin
        r_sent <= r_sent + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pulse_out  = r_pulse;
  assign busy       = (r_state == HIGH) || (r_state == LOW);
  assign done       = (r_state == DONE);
  assign sent_count = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_burst_gen
// Purpose  : Directed self-checking bench for pulse_burst_gen. Expected
//            pulse/busy/done/sent_count values come from the burst timing
//            rules (H high, L low per pulse, done one cycle after N*(H+L)).
// Options  : PULSE_GEN_ABORT_EN - also exercises the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] burst_len;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
`ifdef PULSE_GEN_ABORT_EN
  logic        abort;
`endif
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic [31:0] sent_count;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pulse_burst_gen #(
    .CNT_W (32),
    .PH_W  (16)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .start       (start),
    .burst_len   (burst_len),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
`ifdef PULSE_GEN_ABORT_EN
    .abort       (abort),
`endif
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .sent_count  (sent_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ep, input logic eb,
                           input logic ed, input logic [31:0] es);
    check_eq({tag, " pulse"}, {31'd0, pulse_out}, {31'd0, ep});
    check_eq({tag, " busy"},  {31'd0, busy},      {31'd0, eb});
    check_eq({tag, " done"},  {31'd0, done},      {31'd0, ed});
    check_eq({tag, " sent"},  sent_count,         es);
  endtask

  // Start a burst and check every cycle against the timing rules.
  // disturb_at > 0: at that burst cycle, raise start and change all the
  // burst parameters for one cycle; the running burst must not notice.
  task automatic run_burst(input string name, input int n, input int h,
                           input int l, input int disturb_at);
    int hk, lk, per, total, pos, es;
    logic ep, eb, ed;
    hk    = (h == 0) ? 1 : h;
    lk    = (l == 0) ? 1 : l;
    per   = hk + lk;
    total = n * per;
    burst_len   = 32'(n);
    high_cycles = 16'(h);
    low_cycles  = 16'(l);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= total + 2; c++) begin
      if (c <= total) begin
        pos = (c - 1) % per;
        ep  = (pos < hk);
        eb  = 1'b1;
        ed  = 1'b0;
        es  = (c - 1) / per + ((pos >= hk) ? 1 : 0);
      end else begin
        ep = 1'b0;
        eb = 1'b0;
        ed = (c == total + 1);
        es = n;
      end
      check_all($sformatf("%s c%0d", name, c), ep, eb, ed, 32'(es));
      if (c == disturb_at) begin
        start       = 1'b1;
        burst_len   = 32'd9;
        high_cycles = 16'd7;
        low_cycles  = 16'd7;
      end else if (c == disturb_at + 1) begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    burst_len   = '0;
    high_cycles = '0;
    low_cycles  = '0;
`ifdef PULSE_GEN_ABORT_EN
    abort       = 1'b0;
`endif
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    tick();
    check_all("idle", 1'b0, 1'b0, 1'b0, 32'd0);

    // 3 pulses, 2 high / 3 low: done lands in cycle 16.
    run_burst("b3h2l3", 3, 2, 3, 0);

    // Zero phase lengths behave as one clock each: 8 busy cycles.
    run_burst("b4h0l0", 4, 0, 0, 0);

    // Zero-length request is ignored; sent_count keeps the last value.
    burst_len = 32'd0;
    start     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("len0 %0d", i), 1'b0, 1'b0, 1'b0, 32'd4);
    end
    start = 1'b0;
    tick();

    // Start and parameter change mid-burst have no effect.
    run_burst("mid", 2, 3, 2, 3);

    // Reset during the 2nd high phase of a 5-pulse burst (2 high / 2 low).
    burst_len   = 32'd5;
    high_cycles = 16'd2;
    low_cycles  = 16'd2;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_all("rst pre", 1'b1, 1'b1, 1'b0, 32'd1);
    rst = 1'b1;
    tick();
    check_all("rst hit", 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    tick();
    check_all("rst idle", 1'b0, 1'b0, 1'b0, 32'd0);
    run_burst("after_rst", 2, 1, 1, 0);

`ifdef PULSE_GEN_ABORT_EN
    // Abort in the 3rd high phase of a 10-pulse burst (2 high / 1 low).
    burst_len   = 32'd10;
    high_cycles = 16'd2;
    low_cycles  = 16'd1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_all("abt pre", 1'b1, 1'b1, 1'b0, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all("abt hit", 1'b0, 1'b0, 1'b1, 32'd2);
    tick();
    check_all("abt post", 1'b0, 1'b0, 1'b0, 32'd2);
    // Abort while idle does nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all("abt idle", 1'b0, 1'b0, 1'b0, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
